// File: rtl/dmac_param_engine.sv
// Single-master DMA engine: slave register file, descriptor FIFO and a
// chained copy / fixed-src / fixed-dest / zero-fill transfer FSM.
module dmac_param_engine #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 8,
  parameter int SIZE_W     = 16,
  parameter int DESC_DEPTH = 4
) (
  input  logic              Clk,
  input  logic              reset_n,
  input  logic              S_sel,
  input  logic              S_wr,
  input  logic [7:0]        S_address,
  input  logic [DATA_W-1:0] S_din,
  output logic [DATA_W-1:0] S_dout,
  input  logic              M_grant,
  input  logic [DATA_W-1:0] M_din,
  output logic              M_req,
  output logic              M_wr,
  output logic [ADDR_W-1:0] M_address,
  output logic [DATA_W-1:0] M_dout,
  output logic              Interrupt
);
  localparam int PTR_W = $clog2(DESC_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dest;
    logic [SIZE_W-1:0] size;
    logic [2:0]        mode;
  } desc_t;

  typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_READ, ST_LATCH, ST_WRITE, ST_DONE} state_t;

  state_t            r_state, w_next;
  logic              r_int_en, r_ovf;
  logic [ADDR_W-1:0] r_src, r_dest, r_wsrc, r_wdest;
  logic [SIZE_W-1:0] r_size, r_cnt;
  logic [2:0]        r_mode, r_wmode;
  logic [DATA_W-1:0] r_data;
  desc_t             r_fifo [DESC_DEPTH];
  logic [PTR_W-1:0]  r_wptr, r_rptr;
  logic [CNT_W-1:0]  r_count;

  logic  w_wr, w_clear, w_start, w_push_req, w_push, w_pop;
  logic  w_full, w_empty, w_busy, w_done;
  logic  w_src_fix, w_dst_fix, w_zero;
  desc_t w_head, w_new;
  logic  w_unused;

  assign w_wr       = S_sel & S_wr;
  assign w_clear    = w_wr && (S_address == 8'h00) && S_din[0];
  assign w_start    = w_wr && (S_address == 8'h01) && S_din[0];
  assign w_push_req = w_wr && (S_address == 8'h05) && S_din[0];
  assign w_full     = (r_count == CNT_W'(DESC_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_push     = w_push_req & ~w_full;
  assign w_pop      = (r_state == ST_FETCH);
  assign w_head     = r_fifo[r_rptr];
  assign w_new      = '{src: r_src, dest: r_dest, size: r_size, mode: r_mode};
  assign w_busy     = (r_state == ST_FETCH) || (r_state == ST_READ) ||
                      (r_state == ST_LATCH) || (r_state == ST_WRITE);
  assign w_done     = (r_state == ST_DONE);
  assign w_src_fix  = (r_wmode == 3'b001);
  assign w_dst_fix  = (r_wmode == 3'b010);
  assign w_zero     = (r_wmode == 3'b111);
  assign Interrupt  = w_done & r_int_en;
  assign w_unused   = &{1'b0, S_din[DATA_W-1:SIZE_W]};

  // Staging registers, control bits and the sticky overflow flag
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_int_en <= 1'b0;
      r_ovf    <= 1'b0;
      r_src    <= '0;
      r_dest   <= '0;
      r_size   <= '0;
      r_mode   <= '0;
    end else begin
      if (w_wr) begin
        case (S_address)
          8'h02: r_int_en <= S_din[0];
          8'h03: r_src    <= S_din[ADDR_W-1:0];
          8'h04: r_dest   <= S_din[ADDR_W-1:0];
          8'h07: r_size   <= S_din[SIZE_W-1:0];
          8'h08: r_mode   <= S_din[2:0];
          default: ;
        endcase
      end
      if (w_clear && w_done) r_ovf <= 1'b0;
      if (w_push_req && w_full) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (w_push) r_fifo[r_wptr] <= w_new;
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // In FETCH the head is being popped, so "more queued" means count > 1
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_start && !w_empty) w_next = ST_FETCH;
      ST_FETCH: begin
        if (w_head.size == '0)          w_next = (r_count > CNT_W'(1)) ? ST_FETCH : ST_DONE;
        else if (w_head.mode == 3'b111) w_next = ST_WRITE;
        else                            w_next = ST_READ;
      end
      ST_READ:  if (M_grant) w_next = ST_LATCH;
      ST_LATCH: w_next = ST_WRITE;
      ST_WRITE: begin
        if (M_grant) begin
          if (r_cnt == SIZE_W'(1)) w_next = w_empty ? ST_DONE : ST_FETCH;
          else                     w_next = w_zero ? ST_WRITE : ST_READ;
        end
      end
      ST_DONE:  if (w_clear) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wsrc  <= '0;
      r_wdest <= '0;
      r_cnt   <= '0;
      r_wmode <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          r_wsrc  <= w_head.src;
          r_wdest <= w_head.dest;
          r_cnt   <= w_head.size;
          r_wmode <= w_head.mode;
        end
        ST_LATCH: r_data <= M_din;
        ST_WRITE: begin
          if (M_grant) begin
            r_cnt <= r_cnt - SIZE_W'(1);
            if (!w_src_fix) r_wsrc  <= r_wsrc + ADDR_W'(1);
            if (!w_dst_fix) r_wdest <= r_wdest + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    M_req     = w_busy;
    M_wr      = 1'b0;
    M_address = '0;
    M_dout    = '0;
    case (r_state)
      ST_READ, ST_LATCH: M_address = r_wsrc;
      ST_WRITE: begin
        M_address = r_wdest;
        M_dout    = w_zero ? '0 : r_data;
        M_wr      = M_grant;
      end
      default: ;
    endcase
  end

  always_comb begin
    S_dout = '0;
    if (S_sel && !S_wr) begin
      case (S_address)
        8'h02: S_dout = DATA_W'(r_int_en);
        8'h03: S_dout = DATA_W'(r_src);
        8'h04: S_dout = DATA_W'(r_dest);
        8'h06: S_dout = DATA_W'(r_count);
        8'h07: S_dout = DATA_W'(r_size);
        8'h08: S_dout = DATA_W'(r_mode);
        8'h09: S_dout = DATA_W'({r_ovf, w_full, w_empty, w_busy, w_done});
        default: S_dout = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_dmac_param_engine.sv
// Bench for dmac_param_engine: register vector table, a bus memory model and
// a write scoreboard fed when descriptors are pushed.
module tb_dmac_param_engine;
  localparam int DW = 32, AW = 8, SW = 16, DD = 4;

  logic          Clk = 1'b0, reset_n = 1'b0;
  logic          S_sel = 1'b0, S_wr = 1'b0;
  logic [7:0]    S_address = '0;
  logic [DW-1:0] S_din = '0, S_dout;
  logic          M_grant = 1'b0, M_req, M_wr, Interrupt;
  logic [DW-1:0] M_din, M_dout;
  logic [AW-1:0] M_address;

  dmac_param_engine #(.DATA_W(DW), .ADDR_W(AW), .SIZE_W(SW), .DESC_DEPTH(DD)) dut (
    .Clk(Clk), .reset_n(reset_n), .S_sel(S_sel), .S_wr(S_wr), .S_address(S_address),
    .S_din(S_din), .S_dout(S_dout), .M_grant(M_grant), .M_din(M_din), .M_req(M_req),
    .M_wr(M_wr), .M_address(M_address), .M_dout(M_dout), .Interrupt(Interrupt));

  always #5 Clk = ~Clk;

  int vectors = 0, miscompares = 0, nwr = 0;
  logic [DW-1:0] mem [256];

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wexp_t;
  typedef struct { logic [7:0] addr; logic [31:0] wdata; logic [31:0] exp; } regvec_t;
  wexp_t   sb[$];
  wexp_t   mon_e;
  regvec_t rv [9];

  // Read data appears the cycle after the address was presented
  always @(posedge Clk) M_din <= mem[M_address];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (reset_n && M_wr) begin
      nwr++;
      check("wr_req_grant", {30'd0, M_req, M_grant}, 32'd3);
      if (sb.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none", M_address, M_dout);
      end else begin
        mon_e = sb.pop_front();
        check("wr_addr", M_address, mon_e.addr);
        check("wr_data", M_dout, mon_e.data);
      end
    end
  end

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(posedge Clk); #1;
    S_sel = 1'b1; S_wr = 1'b1; S_address = a; S_din = d;
    @(posedge Clk); #1;
    S_sel = 1'b0; S_wr = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [7:0] a, input logic [31:0] exp);
    @(posedge Clk); #1;
    S_sel = 1'b1; S_wr = 1'b0; S_address = a;
    #2 check(name, S_dout, exp);
    S_sel = 1'b0;
  endtask

  task automatic push_desc(input logic [7:0] s, input logic [7:0] d, input logic [15:0] sz,
                           input logic [2:0] md, input bit accept);
    logic [7:0] as, ad;
    wr(8'h03, {24'd0, s}); wr(8'h04, {24'd0, d}); wr(8'h07, {16'd0, sz}); wr(8'h08, {29'd0, md});
    wr(8'h05, 32'd1);
    if (accept) begin
      for (int k = 0; k < int'(sz); k++) begin
        as = (md == 3'b001) ? s : s + 8'(k);
        ad = (md == 3'b010) ? d : d + 8'(k);
        sb.push_back('{ad, (md == 3'b111) ? 32'd0 : mem[as]});
      end
    end
  endtask

  task automatic wait_done(output int reqcyc);
    bit ok;
    ok = 0; reqcyc = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge Clk);
      if (Interrupt) begin ok = 1; break; end
      if (M_req) reqcyc++;
    end
    check("done_reached", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_wr();
    bit ok;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      if (M_wr) begin ok = 1; break; end
    end
    check("first_write_seen", {31'd0, ok}, 32'd1);
  endtask

  int rc, nwr0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;
    mem[8'h0A] = 32'd100; mem[8'h0B] = 32'd200; mem[8'h0C] = 32'd300; mem[8'h0D] = 32'd400;
    rv[0] = '{8'h03, 32'h1AB,   32'hAB};
    rv[1] = '{8'h04, 32'h3C,    32'h3C};
    rv[2] = '{8'h07, 32'h12345, 32'h2345};
    rv[3] = '{8'h08, 32'hFF,    32'h7};
    rv[4] = '{8'h02, 32'h3,     32'h1};
    rv[5] = '{8'h0C, 32'h55,    32'h0};
    rv[6] = '{8'h06, 32'h7,     32'h0};
    rv[7] = '{8'h09, 32'h1F,    32'h4};
    rv[8] = '{8'h02, 32'h0,     32'h0};

    // Reset state
    #3;
    check("rst_m_req", {31'd0, M_req}, 32'd0);
    check("rst_int", {31'd0, Interrupt}, 32'd0);
    check("rst_m_addr", {24'd0, M_address}, 32'd0);
    @(posedge Clk); #1 reset_n = 1'b1;
    rd_check("rst_status", 8'h09, 32'h04);
    rd_check("rst_dcount", 8'h06, 32'h0);

    foreach (rv[i]) begin
      wr(rv[i].addr, rv[i].wdata);
      rd_check($sformatf("reg_%0h", rv[i].addr), rv[i].addr, rv[i].exp);
    end

    // Plain copy of four words
    M_grant = 1'b1;
    wr(8'h02, 32'd1);
    push_desc(8'h0A, 8'h14, 16'd4, 3'b000, 1);
    rd_check("copy_dcount", 8'h06, 32'd1);
    wr(8'h01, 32'd1);
    wait_done(rc);
    check("copy_req_cycles", rc, 32'd13);
    check("copy_drained", sb.size(), 32'd0);
    rd_check("copy_status", 8'h09, 32'h05);
    wr(8'h00, 32'd1);
    #2 check("clear_int", {31'd0, Interrupt}, 32'd0);
    rd_check("clear_status", 8'h09, 32'h04);

    // Chained copy then zero-fill
    push_desc(8'h20, 8'h30, 16'd2, 3'b000, 1);
    push_desc(8'h00, 8'h40, 16'd3, 3'b111, 1);
    nwr0 = nwr;
    wr(8'h01, 32'd1);
    wait_done(rc);
    check("chain_writes", nwr - nwr0, 32'd5);
    check("chain_drained", sb.size(), 32'd0);
    wr(8'h00, 32'd1);

    // Overflow, then four empty descriptors complete with no writes
    for (int i = 0; i < DD + 1; i++) push_desc(8'h00, 8'h00, 16'd0, 3'b000, 1);
    rd_check("ovf_dcount", 8'h06, DD);
    rd_check("ovf_status", 8'h09, 32'h18);
    nwr0 = nwr;
    wr(8'h01, 32'd1);
    wait_done(rc);
    check("size0_no_wr", nwr - nwr0, 32'd0);
    rd_check("size0_status", 8'h09, 32'h15);
    wr(8'h00, 32'd1);
    rd_check("ovf_cleared", 8'h09, 32'h04);

    // Destination wraps past the top of the address space
    push_desc(8'h05, 8'hFF, 16'd2, 3'b000, 1);
    wr(8'h01, 32'd1);
    wait_done(rc);
    check("wrap_drained", sb.size(), 32'd0);
    wr(8'h00, 32'd1);

    // Grant loss mid zero-fill; START/CLEAR while busy are ignored
    push_desc(8'h00, 8'h50, 16'd4, 3'b111, 1);
    wr(8'h01, 32'd1);
    wait_wr();
    @(posedge Clk); #1 M_grant = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      check("stall_no_wr", {31'd0, M_wr}, 32'd0);
      check("stall_addr", {24'd0, M_address}, 32'h51);
      check("stall_req", {31'd0, M_req}, 32'd1);
    end
    wr(8'h01, 32'd1);
    wr(8'h00, 32'd1);
    rd_check("busy_status", 8'h09, 32'h06);
    check("stall_addr_after", {24'd0, M_address}, 32'h51);
    M_grant = 1'b1;
    wait_done(rc);
    check("stall_drained", sb.size(), 32'd0);
    rd_check("stall_done_status", 8'h09, 32'h05);
    wr(8'h00, 32'd1);

    // Reset while writing aborts and empties the queue
    push_desc(8'h60, 8'h70, 16'd4, 3'b000, 1);
    push_desc(8'h61, 8'h80, 16'd2, 3'b010, 1);
    wr(8'h01, 32'd1);
    wait_wr();
    #2 reset_n = 1'b0;
    #1;
    check("arst_m_req", {31'd0, M_req}, 32'd0);
    check("arst_m_wr", {31'd0, M_wr}, 32'd0);
    check("arst_m_addr", {24'd0, M_address}, 32'd0);
    check("arst_m_dout", M_dout, 32'd0);
    sb.delete();
    @(posedge Clk); #1 reset_n = 1'b1;
    rd_check("arst_dcount", 8'h06, 32'd0);
    rd_check("arst_status", 8'h09, 32'h04);
    check("arst_int", {31'd0, Interrupt}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
